// File: rtl/dtc_mon_mux.sv
// dtc_mon_mux: DTC monitor selector with auto-scan, snapshot handshake and select-range checking.
// Optional DTC_MON_TOGGLE_CNT_EN adds mon_tog_cnt, a saturating data-toggle counter.
module dtc_mon_mux #(
  parameter int N_CH    = 40,
  parameter int DW      = 16,
  parameter int SEL_W   = 6,
  parameter int DWELL_W = 16
) (
  input  logic               dcsclk,
  input  logic               dcs_rst_n,
  input  logic [N_CH*DW-1:0] dtc_dout,
  input  logic [SEL_W-1:0]   mon_sel,
  input  logic               scan_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               snap_req,
  input  logic               snap_ack,
  input  logic               clr_flags,
  output logic [DW-1:0]      mon_dout,
  output logic [SEL_W-1:0]   mon_ch,
  output logic               sel_err,
  output logic [DW-1:0]      snap_dout,
  output logic [SEL_W-1:0]   snap_ch,
  output logic               snap_valid,
  output logic               snap_ovr,
  output logic               scan_wrap
`ifdef DTC_MON_TOGGLE_CNT_EN
  , output logic [15:0]      mon_tog_cnt
`endif
);
  localparam logic [SEL_W:0]   N_CH_W = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_CH - 1);
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t state;
  logic [SEL_W-1:0] scan_ch, eff_ch;
  logic [DWELL_W-1:0] cnt, lim;
  logic [DW-1:0] word;
  logic sel_bad, adv, last, snap_take;
  always_comb begin
    sel_bad = {1'b0, mon_sel} >= N_CH_W;
    eff_ch = (state == SCAN) ? scan_ch : (sel_bad ? '0 : mon_sel);
    word = dtc_dout[eff_ch*DW +: DW];
    lim = (dwell == '0) ? DWELL_W'(1) : dwell;
    // >= rather than == so a dwell shortened below the running count advances at once
    adv = cnt >= lim - DWELL_W'(1);
    last = scan_ch == LAST;
    snap_take = snap_req && (!snap_valid || snap_ack);
  end
  always_ff @(posedge dcsclk or negedge dcs_rst_n)
    if (!dcs_rst_n) begin
      state <= MANUAL;
      scan_ch <= '0;
      cnt <= '0;
      mon_dout <= '0;
      mon_ch <= '0;
      sel_err <= 1'b0;
      snap_dout <= '0;
      snap_ch <= '0;
      snap_valid <= 1'b0;
      snap_ovr <= 1'b0;
      scan_wrap <= 1'b0;
`ifdef DTC_MON_TOGGLE_CNT_EN
      mon_tog_cnt <= '0;
`endif
    end else begin
      mon_dout <= word;
      mon_ch <= eff_ch;
      sel_err <= (state == MANUAL && sel_bad) || (sel_err && !clr_flags);
      snap_ovr <= (snap_req && snap_valid && !snap_ack) || (snap_ovr && !clr_flags);
      snap_valid <= snap_take || (snap_valid && !snap_ack);
      if (snap_take) begin
        snap_dout <= word;
        snap_ch <= eff_ch;
      end
      scan_wrap <= state == SCAN && adv && last;
      if (state == MANUAL) begin
        if (scan_en) begin
          state <= SCAN;
          scan_ch <= '0;
          cnt <= '0;
        end
      end else begin
        if (!scan_en) state <= MANUAL;
        cnt <= adv ? '0 : cnt + DWELL_W'(1);
        if (adv) scan_ch <= last ? '0 : scan_ch + SEL_W'(1);
      end
`ifdef DTC_MON_TOGGLE_CNT_EN
      mon_tog_cnt <= (eff_ch != mon_ch) ? '0 :
                     (word != mon_dout) ? (clr_flags ? 16'd1 : mon_tog_cnt + {15'd0, mon_tog_cnt != 16'hFFFF}) :
                     (clr_flags ? '0 : mon_tog_cnt);
`endif
    end
endmodule
